// File: rtl/mac_job_seq.sv
// mac_job_seq: job sequencer for a 7-lane, 2-stage MAC (abs-diff-sum or dot product).
// Pulls operand beats by valid/ready, tracks which MAC results are real beats
// (bubbles are clocked through but never summed), and accumulates the per-beat
// results into a signed ACC_W total reported with a one-cycle done pulse.
// Optional build macro MAC_JOB_SEQ_SAT_EN: saturating accumulation plus a
// sticky sat_flag output; without it the total wraps in two's complement.
module mac_job_seq #(
   parameter int BEAT_W = 8,
   parameter int MAC_W  = 21,
   parameter int ACC_W  = 29
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic                    op_in,
   input  logic [BEAT_W-1:0]       beats_in,
   output logic                    busy,
   output logic                    done,
   output logic signed [ACC_W-1:0] result,
   input  logic                    src_valid,
   output logic                    src_ready,
   output logic                    mac_enable,
   output logic                    mac_op,
   input  logic signed [MAC_W-1:0] mac_data_out
`ifdef MAC_JOB_SEQ_SAT_EN
   ,
   output logic                    sat_flag
`endif
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]              r_state;
   logic [BEAT_W-1:0]       r_cnt;
   logic                    r_mac_op;
   logic                    r_vld_p0;
   logic                    r_vld_p1;
   logic signed [ACC_W-1:0] r_acc;
   logic signed [ACC_W-1:0] r_result;

   logic                    w_accept;
   logic                    w_issue;
   logic                    w_acc_en;
   logic                    w_drain_done;
   logic signed [ACC_W-1:0] w_beat_ext;
   logic signed [ACC_W-1:0] w_acc_nxt;

   // Sign-extend one MAC beat result to the accumulator width.
   function automatic logic signed [ACC_W-1:0] sext_mac(input logic signed [MAC_W-1:0] x);
      return {{(ACC_W-MAC_W){x[MAC_W-1]}}, x};
   endfunction

`ifdef MAC_JOB_SEQ_SAT_EN
   logic                    r_sat;
   logic                    w_ovf;
   logic signed [ACC_W:0]   w_sum_wide;

   // Clamp a one-bit-wider sum to the signed ACC_W range.
   function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
      if (s[ACC_W] != s[ACC_W-1])
         return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      return s[ACC_W-1:0];
   endfunction

   assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_beat_ext[ACC_W-1], w_beat_ext};
   assign w_ovf      = w_acc_en & (w_sum_wide[ACC_W] != w_sum_wide[ACC_W-1]);
   assign w_acc_nxt  = w_acc_en ? sat_acc(w_sum_wide) : r_acc;
   assign sat_flag   = r_sat;
`else
   assign w_acc_nxt  = w_acc_en ? (r_acc + w_beat_ext) : r_acc;
`endif

   assign w_accept     = (r_state == IDLE) & start;
   assign w_issue      = src_valid & src_ready;
   assign w_acc_en     = mac_enable & r_vld_p1;
   assign w_drain_done = (r_state == DRAIN) & ~r_vld_p0;
   assign w_beat_ext   = sext_mac(mac_data_out);

   assign busy       = (r_state != IDLE);
   assign done       = (r_state == DONE);
   assign src_ready  = (r_state == RUN);
   assign mac_enable = (r_state == RUN) | (r_state == DRAIN);
   assign mac_op     = r_mac_op;
   assign result     = r_result;

   // Job FSM: accept a start in IDLE, count issued beats in RUN, wait out the MAC in DRAIN.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_mac_op <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (beats_in != '0) begin
                     r_mac_op <= op_in;
                     r_cnt    <= beats_in;
                     r_state  <= RUN;
                  end else begin
                     r_state  <= DONE;
                  end
               end
            end
            RUN: begin
               if (w_issue) begin
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == BEAT_W'(1))
                     r_state <= DRAIN;
               end
            end
            DRAIN: begin
               // Leaving once stage 0 is empty: the last real beat is summed on this same edge.
               if (!r_vld_p0)
                  r_state <= DONE;
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Valid pipe mirroring the MAC's two register stages; it only advances when the MAC does.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_p0 <= 1'b0;
         r_vld_p1 <= 1'b0;
      end else if (mac_enable) begin
         r_vld_p0 <= w_issue;
         r_vld_p1 <= r_vld_p0;
      end
   end

   // Accumulator and held job result (plus sticky saturation flag when enabled).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc    <= '0;
         r_result <= '0;
`ifdef MAC_JOB_SEQ_SAT_EN
         r_sat    <= 1'b0;
`endif
      end else if (w_accept) begin
         r_acc <= '0;
`ifdef MAC_JOB_SEQ_SAT_EN
         r_sat <= 1'b0;
`endif
         if (beats_in == '0)
            r_result <= '0;
      end else begin
         r_acc <= w_acc_nxt;
`ifdef MAC_JOB_SEQ_SAT_EN
         r_sat <= r_sat | w_ovf;
`endif
         if (w_drain_done)
            r_result <= w_acc_nxt;
      end
   end

endmodule

// File: tb/tb_mac_job_seq.sv
// Bench for mac_job_seq: directed job table, hand-written reset sequence and
// randomized jobs, all checked against a beat-level arithmetic model.
module tb_mac_job_seq;
   localparam int BEAT_W = 8;
   localparam int MAC_W  = 21;
`ifdef MAC_JOB_SEQ_SAT_EN
   localparam int ACC_W  = 22;
`else
   localparam int ACC_W  = 29;
`endif

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    start = 1'b0;
   logic                    op_in = 1'b0;
   logic [BEAT_W-1:0]       beats_in = '0;
   logic                    busy, done, src_ready, mac_enable, mac_op;
   logic signed [ACC_W-1:0] result;
   logic                    src_valid = 1'b0;
   logic signed [MAC_W-1:0] mac_data_out = '0;
`ifdef MAC_JOB_SEQ_SAT_EN
   logic                    sat_flag;
`endif

   mac_job_seq #(.BEAT_W(BEAT_W), .MAC_W(MAC_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .reset(reset), .start(start), .op_in(op_in), .beats_in(beats_in),
      .busy(busy), .done(done), .result(result), .src_valid(src_valid),
      .src_ready(src_ready), .mac_enable(mac_enable), .mac_op(mac_op),
      .mac_data_out(mac_data_out)
`ifdef MAC_JOB_SEQ_SAT_EN
      , .sat_flag(sat_flag)
`endif
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   logic [55:0] la = '0, lb = '0;
   logic [55:0] ja[256], jb[256];
   bit          vp[8];
   int          vplen = 1;
   bit          mforce = 1'b0;
   longint      mforce_val = 0;
   bit          m_ovf;
   logic signed [MAC_W-1:0] mac_s1 = '0;

   // Value one beat produces: 7 lanes of signed 8-bit pairs.
   function automatic longint beat_val(input bit op, input logic [55:0] a, input logic [55:0] b);
      longint s, x, y;
      logic signed [7:0] ta, tb;
      if (mforce) return mforce_val;
      s = 0;
      for (int i = 0; i < 7; i++) begin
         ta = a[i*8 +: 8];
         tb = b[i*8 +: 8];
         x = longint'(ta);
         y = longint'(tb);
         if (op) s += x * y;
         else    s += (x > y) ? x - y : y - x;
      end
      return s;
   endfunction

   function automatic longint mac21(input longint v);
      logic signed [MAC_W-1:0] t;
      t = MAC_W'(v);
      return longint'(t);
   endfunction

   function automatic longint acc_add(input longint acc, input longint v);
      longint s, m, hi, lo;
      m  = longint'(1) << ACC_W;
      hi = (m / 2) - 1;
      lo = -(m / 2);
      s  = acc + v;
`ifdef MAC_JOB_SEQ_SAT_EN
      if (s > hi) begin s = hi; m_ovf = 1'b1; end
      else if (s < lo) begin s = lo; m_ovf = 1'b1; end
`else
      s = s & (m - 1);
      if (s > hi) s -= m;
`endif
      return s;
   endfunction

   // External MAC: two enabled register stages computing from the presented operands.
   always @(posedge clk) begin
      if (mac_enable) begin
         mac_s1       <= MAC_W'(beat_val(mac_op, la, lb));
         mac_data_out <= mac_s1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input longint act, input longint req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; src_valid = 1'b0;
      tick(); tick();
      reset = 1'b0;
   endtask

   // Run one job from start to the cycle after done and check everything about it.
   task automatic run_job(input bit op, input int nb, input bit poke, input string nm);
      longint exp;
      int idx, k, hs, last, cyc, dcyc, en_n, exp_d, exp_en;
      bit op_bad, vld;
      exp = 0; idx = 0; k = 0; hs = 0; last = -1; dcyc = -1; en_n = 0; op_bad = 1'b0;
      m_ovf = 1'b0;
      for (int i = 0; i < nb; i++) exp = acc_add(exp, mac21(beat_val(op, ja[i], jb[i])));
      start = 1'b1; op_in = op; beats_in = BEAT_W'(nb); src_valid = 1'b0;
      tick();
      cyc = 1; start = 1'b0; op_in = ~op; beats_in = BEAT_W'($urandom);
      while (cyc < 2000) begin
         if (nb != 0 && busy && mac_op !== op) op_bad = 1'b1;
         if (done) begin dcyc = cyc; break; end
         if (mac_enable) en_n++;
         vld = (idx < nb) ? vp[k % vplen] : 1'($urandom_range(0, 1));
         src_valid = vld;
         la = (vld && idx < nb) ? ja[idx] : 56'({$urandom(), $urandom()});
         lb = (vld && idx < nb) ? jb[idx] : 56'({$urandom(), $urandom()});
         if (poke) begin
            start = 1'($urandom_range(0, 1)); op_in = 1'($urandom_range(0, 1));
            beats_in = BEAT_W'($urandom);
         end
         if (src_valid && src_ready) begin hs++; idx++; last = cyc; end
         k++;
         tick();
         cyc++;
      end
      start = 1'b0;
      src_valid = 1'($urandom_range(0, 1));
      exp_d  = (nb == 0) ? 1 : last + 3;
      exp_en = (nb == 0) ? 0 : last + 2;
      chk({nm, "_done_cycle"}, dcyc, exp_d);
      chk({nm, "_result"}, longint'(result), exp);
`ifdef MAC_JOB_SEQ_SAT_EN
      chk({nm, "_sat_flag"}, longint'(sat_flag), longint'(m_ovf));
`endif
      chk({nm, "_handshakes"}, hs, nb);
      chk({nm, "_enable_cycles"}, en_n, exp_en);
      chk({nm, "_mac_op_stable"}, longint'(op_bad), 0);
      if (poke) begin start = 1'b1; beats_in = BEAT_W'($urandom_range(1, 9)); end
      tick();
      start = 1'b0;
      chk({nm, "_idle_after"}, longint'({busy, done, src_ready, mac_enable}), 0);
      chk({nm, "_result_hold"}, longint'(result), exp);
      if (dcyc < 0) do_reset();
   endtask

   typedef struct {
      bit          op;
      int          nb;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  pat;
      int          plen;
      bit          poke;
      longint      exp;
   } vec_t;

   vec_t tv[6];

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tv[0] = '{op:1'b0, nb:4,   a:8'd5,   b:8'd2,   pat:8'h01, plen:1, poke:1'b0, exp:84};
      tv[1] = '{op:1'b1, nb:3,   a:8'hFE,  b:8'd5,   pat:8'h01, plen:1, poke:1'b1, exp:-210};
      tv[2] = '{op:1'b0, nb:5,   a:8'd1,   b:8'd4,   pat:8'hD9, plen:8, poke:1'b0, exp:105};
      tv[3] = '{op:1'b0, nb:0,   a:8'd0,   b:8'd0,   pat:8'h01, plen:1, poke:1'b0, exp:0};
      tv[4] = '{op:1'b1, nb:1,   a:8'd127, b:8'h80,  pat:8'h01, plen:1, poke:1'b1, exp:-113792};
      tv[5] = '{op:1'b0, nb:255, a:8'h80,  b:8'd127, pat:8'h05, plen:3, poke:1'b0, exp:455175};

      do_reset();
      chk("reset_busy", longint'(busy), 0);
      chk("reset_done", longint'(done), 0);
      chk("reset_src_ready", longint'(src_ready), 0);
      chk("reset_mac_enable", longint'(mac_enable), 0);
      chk("reset_mac_op", longint'(mac_op), 0);
      chk("reset_result", longint'(result), 0);
`ifdef MAC_JOB_SEQ_SAT_EN
      chk("reset_sat_flag", longint'(sat_flag), 0);
`endif

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 256; i++) begin ja[i] = {7{tv[t].a}}; jb[i] = {7{tv[t].b}}; end
         for (int i = 0; i < 8; i++) vp[i] = tv[t].pat[i];
         vplen = tv[t].plen;
         run_job(tv[t].op, tv[t].nb, tv[t].poke, $sformatf("vec%0d", t));
         chk($sformatf("vec%0d_table_result", t), longint'(result), tv[t].exp);
      end

      // Reset in RUN after two issues, then a clean 1-beat job.
      for (int i = 0; i < 256; i++) begin ja[i] = {7{8'd9}}; jb[i] = {7{8'd1}}; end
      start = 1'b1; op_in = 1'b0; beats_in = 8'd5;
      tick();
      start = 1'b0; src_valid = 1'b1; la = ja[0]; lb = jb[0];
      tick();
      la = ja[1]; lb = jb[1];
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midreset_busy", longint'(busy), 0);
      chk("midreset_result", longint'(result), 0);
      chk("midreset_done", longint'(done), 0);
      tick();
      chk("idle_src_ready", longint'({src_ready, mac_enable}), 0);
      for (int i = 0; i < 256; i++) begin ja[i] = {7{8'd3}}; jb[i] = {7{8'd2}}; end
      vp[0] = 1'b1; vplen = 1;
      run_job(1'b0, 1, 1'b0, "post_reset");
      chk("post_reset_is_7", longint'(result), 7);

`ifdef MAC_JOB_SEQ_SAT_EN
      mforce = 1'b1; mforce_val = (longint'(1) << 20) - 1;
      run_job(1'b0, 3, 1'b0, "sat");
      chk("sat_limit", longint'(result), (longint'(1) << 21) - 1);
      chk("sat_flag_set", longint'(sat_flag), 1);
      mforce = 1'b0;
`endif

      for (int j = 0; j < 10; j++) begin
         int nb;
         logic [7:0] p;
         nb = (j == 3) ? 0 : $urandom_range(1, 40);
         for (int i = 0; i < nb; i++) begin
            ja[i] = 56'({$urandom(), $urandom()});
            jb[i] = 56'({$urandom(), $urandom()});
         end
         p = 8'($urandom);
         p[0] = 1'b1;
         for (int i = 0; i < 8; i++) vp[i] = p[i];
         vplen = $urandom_range(1, 8);
         run_job(1'($urandom_range(0, 1)), nb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", j));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/mac_job_seq.md
Name: mac_job_seq

Overview:
- Sequences one 7-lane MAC (abs-diff-sum or signed dot product) over a multi-beat job, e.g. a template/candidate SAD or a weight dot product for one particle.
- Pulls operand beats from an upstream source by valid/ready handshake; the operand buses route directly from the source to the MAC.
- Drives the MAC enable and op, and tracks the MAC's 2-stage pipeline.
- Accumulates the 21-bit per-beat MAC results into a wide signed total and reports it with a done pulse.

Parameters:
- BEAT_W, 8, width of the beat-count field; jobs of 0..2^BEAT_W-1 beats.
- MAC_W, 21, width of the MAC data_out.
- ACC_W, 29, accumulator/result width (MAC_W + BEAT_W).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  job request; sampled only in IDLE
- op_in  in  1  job op: 0 = abs-sub, 1 = multiply
- beats_in  in  BEAT_W  number of operand beats in the job
- busy  out  1  high in RUN, DRAIN and DONE
- done  out  1  one-cycle pulse when result is final
- result  out  ACC_W  signed job total; held until the next accepted start
- src_valid  in  1  source presents a 7-pair operand beat
- src_ready  out  1  controller consumes the beat this cycle
- mac_enable  out  1  MAC register enable
- mac_op  out  1  MAC op select
- mac_data_out  in  MAC_W  MAC registered result, signed

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. All state updates on the rising edge of clk only.
- Reset values:
  - state = IDLE; busy, done, src_ready, mac_enable = 0.
  - mac_op = 0; result = 0; accumulator, beat counter and valid pipe = 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with beats_in≠0: latch op_in into mac_op, load beats_in into the counter, clear the accumulator, go to RUN.
  - start=1 with beats_in=0: go directly to DONE with result=0.
- RUN:
  - mac_enable=1; src_ready=1.
  - An issue is src_valid & src_ready; each issue decrements the counter.
  - On the issue that takes the counter to 0, go to DRAIN.
  - src_valid=0 creates a bubble: the MAC still clocks, but the bubble is never accumulated.
- DRAIN: mac_enable=1, src_ready=0; go to DONE once the valid pipe is empty.
- DONE: done=1 for exactly one cycle, result = accumulator; next state IDLE.
- MAC pipeline tracking:
  - Valid pipe v[1:0] shifts every cycle that mac_enable=1; v[0] <= issue, v[1] <= v[0].
  - When v[1]=1, mac_data_out holds that beat's result; add it, sign-extended from MAC_W to ACC_W, to the accumulator at that edge.
  - An issue in cycle t is therefore accumulated at the end of cycle t+2.
- Latency: N beats with src_valid held high, start accepted in cycle 0 → issues in cycles 1..N, DRAIN in N+1..N+2, done in cycle N+3.
- Accumulation:
  - Both ops use the same signed add.
  - Wraps modulo 2^ACC_W unless the optional feature below is enabled.
- mac_op is constant for the whole job and changes only on an accepted start.
- Boundary conditions:
  - start outside IDLE is ignored, with no effect on the running job.
  - start in the same cycle as done is ignored.
  - Reset mid-job returns to IDLE next edge, drops in-flight beats and clears result.
  - src_valid while not in RUN is not consumed (src_ready=0).
  - beats_in and op_in are ignored after acceptance.

Optional Feature:
- Macro: MAC_JOB_SEQ_SAT_EN.
- Defined: accumulator additions saturate to the signed ACC_W limits (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)). A sticky overflow bit marks the job; it is cleared on start and exposed on extra output port sat_flag (1 bit, reset 0, valid with done).
- Undefined: two's-complement wrap, and no sat_flag port.

Test Plan:
- SAD, op_in=0, beats_in=4, src_valid held high, each lane diff = 3 → done in cycle 7 after start; result=84; exactly 4 src_ready&src_valid handshakes.
- Dot product, op_in=1, beats_in=3, each lane (-2)×5 → MAC gives -70 per beat; result=-210 (sign-extended); mac_op=1 throughout busy.
- Stalls: beats_in=5, src_valid pattern 1,0,0,1,1,0,1,1 → only 5 beats accumulated, bubbles ignored; done 3 cycles after the 5th issue.
- beats_in=0 with start → done one cycle later with result=0; no src_ready and no mac_enable asserted.
- Reset asserted in RUN after 2 issues → next cycle IDLE, result=0, busy=0. A following job of 1 beat (diff 1 × 7 lanes) → result=7, with no carry-over.
- start pulsed during RUN and DRAIN → ignored; the original job's result is unchanged. With MAC_JOB_SEQ_SAT_EN, ACC_W=22, 3 beats of +2^20-1 → result=2^21-1, sat_flag=1.
